// File: rtl/tx_spec_shift_if.sv
// Streaming I/Q handshake bundle for tx_spec_shift.
// slave = the shifter's view, master = the source/sink around it.
interface tx_spec_shift_if #(parameter int unsigned W = 14);
   logic                in_valid;
   logic                in_ready;
   logic                in_sos;
   logic signed [W-1:0] in_i;
   logic signed [W-1:0] in_q;
   logic                out_valid;
   logic                out_ready;
   logic                out_sos;
   logic signed [W-1:0] out_i;
   logic signed [W-1:0] out_q;

   modport slave (
      input  in_valid, in_sos, in_i, in_q, out_ready,
      output in_ready, out_valid, out_sos, out_i, out_q
   );

   modport master (
      output in_valid, in_sos, in_i, in_q, out_ready,
      input  in_ready, out_valid, out_sos, out_i, out_q
   );
endinterface

// File: rtl/tx_spec_shift.sv
// Digital frequency shifter: bypass, fs/2 or +/-fs/4 rotation of an I/Q stream,
// phase re-aligned and mode re-latched at each start-of-symbol sample.
module tx_spec_shift #(
   parameter int unsigned W = 14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   tx_spec_shift_if.slave s
);
   localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   // rotation selector encoding
   localparam logic [1:0] SEL_ID  = 2'd0;  // ( i,  q)
   localparam logic [1:0] SEL_NEG = 2'd1;  // (-i, -q)
   localparam logic [1:0] SEL_P90 = 2'd2;  // (-q,  i)
   localparam logic [1:0] SEL_M90 = 2'd3;  // ( q, -i)

   logic [1:0]          p;
   logic [1:0]          mode_r;
   logic                ov_r;
   logic                osos_r;
   logic signed [W-1:0] oi_r;
   logic signed [W-1:0] oq_r;

   logic                in_rdy;
   logic                in_acc;
   logic                out_acc;
   logic [1:0]          p_use;
   logic [1:0]          mode_use;
   logic [1:0]          sel;
   logic signed [W-1:0] nx_i;
   logic signed [W-1:0] nx_q;

   function automatic logic signed [W-1:0] sneg(input logic signed [W-1:0] x);
      return (x == SMIN) ? SMAX : -x;
   endfunction

   assign in_rdy  = en & ~rst & (~ov_r | s.out_ready);
   assign in_acc  = s.in_valid & in_rdy;
   assign out_acc = en & ov_r & s.out_ready;

   // A start-of-symbol sample forces phase 0 and takes the live mode.
   always_comb begin
      p_use    = s.in_sos ? 2'd0 : p;
      mode_use = s.in_sos ? mode : mode_r;
      sel      = SEL_ID;
      unique case (mode_use)
         2'b00: sel = SEL_ID;
         2'b01: sel = p_use[0] ? SEL_NEG : SEL_ID;
         2'b10: begin
            unique case (p_use)
               2'd0: sel = SEL_ID;
               2'd1: sel = SEL_P90;
               2'd2: sel = SEL_NEG;
               2'd3: sel = SEL_M90;
               default: sel = SEL_ID;
            endcase
         end
         2'b11: begin
            unique case (p_use)
               2'd0: sel = SEL_ID;
               2'd1: sel = SEL_M90;
               2'd2: sel = SEL_NEG;
               2'd3: sel = SEL_P90;
               default: sel = SEL_ID;
            endcase
         end
         default: sel = SEL_ID;
      endcase

      nx_i = s.in_i;
      nx_q = s.in_q;
      unique case (sel)
         SEL_ID:  begin nx_i = s.in_i;       nx_q = s.in_q;       end
         SEL_NEG: begin nx_i = sneg(s.in_i); nx_q = sneg(s.in_q); end
         SEL_P90: begin nx_i = sneg(s.in_q); nx_q = s.in_i;       end
         SEL_M90: begin nx_i = s.in_q;       nx_q = sneg(s.in_i); end
         default: begin nx_i = s.in_i;       nx_q = s.in_q;       end
      endcase
   end

   // One-stage output register; a new accept takes priority over draining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p      <= 2'd0;
         mode_r <= 2'b00;
         ov_r   <= 1'b0;
         osos_r <= 1'b0;
         oi_r   <= '0;
         oq_r   <= '0;
      end else if (in_acc) begin
         p      <= 2'(p_use + 2'd1);
         if (s.in_sos) mode_r <= mode;
         ov_r   <= 1'b1;
         osos_r <= s.in_sos;
         oi_r   <= nx_i;
         oq_r   <= nx_q;
      end else if (out_acc) begin
         ov_r   <= 1'b0;
      end
   end

   assign s.in_ready  = in_rdy;
   assign s.out_valid = ov_r;
   assign s.out_sos   = osos_r;
   assign s.out_i     = oi_r;
   assign s.out_q     = oq_r;
endmodule
